csr_bus_arbiter: RTL

CSR_BUS_ARBITER -- requirements
Module: csr_bus_arbiter

---
 rtl/csr_bus_arbiter.sv | 80 ++++++++
 1 files changed

// File: rtl/csr_bus_arbiter.sv
// csr_bus_arbiter: round-robin arbitration of two CSR requesters onto one shared CSR port
module csr_bus_arbiter #(
  parameter int CSR_ADDR_WIDTH = 8,
  parameter int CSR_DATA_WIDTH = 32,
  parameter logic [CSR_ADDR_WIDTH-1:0] ADDR_LO = 8'h50,
  parameter logic [CSR_ADDR_WIDTH-1:0] ADDR_HI = 8'h54
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      p0_req_valid,
  output logic                      p0_req_ready,
  input  logic                      p0_req_we,
  input  logic [CSR_ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [CSR_DATA_WIDTH-1:0] p0_req_wdata,
  output logic                      p0_rsp_valid,
  input  logic                      p0_rsp_ready,
  output logic [CSR_DATA_WIDTH-1:0] p0_rsp_rdata,
  output logic                      p0_rsp_err,
  input  logic                      p1_req_valid,
  output logic                      p1_req_ready,
  input  logic                      p1_req_we,
  input  logic [CSR_ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [CSR_DATA_WIDTH-1:0] p1_req_wdata,
  output logic                      p1_rsp_valid,
  input  logic                      p1_rsp_ready,
  output logic [CSR_DATA_WIDTH-1:0] p1_rsp_rdata,
  output logic                      p1_rsp_err,
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr,
  output logic                      csr_wen,
  output logic                      csr_ren,
  output logic [CSR_DATA_WIDTH-1:0] csr_wdata,
  input  logic [CSR_DATA_WIDTH-1:0] csr_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nx;
  logic ptr, id, we, err, win, grant, legal, done;
  logic [CSR_DATA_WIDTH-1:0] rdata;
  assign win = (p0_req_valid && p1_req_valid) ? ptr : p1_req_valid;
  assign grant = (state == IDLE) && (p0_req_valid || p1_req_valid) && !rst;
  assign legal = (csr_addr >= ADDR_LO) && (csr_addr <= ADDR_HI);
  assign done = (state == RESP) && (id ? p1_rsp_ready : p0_rsp_ready);
  always_comb begin
    state_nx = (state == IDLE) ? (grant ? ISSUE : IDLE) : (state == ISSUE) ? RESP : (done ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= 1'b0;
      id <= 1'b0;
      we <= 1'b0;
      err <= 1'b0;
      rdata <= '0;
      csr_addr <= '0;
      csr_wdata <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        id <= win;
        we <= win ? p1_req_we : p0_req_we;
        csr_addr <= win ? p1_req_addr : p0_req_addr;
        csr_wdata <= win ? p1_req_wdata : p0_req_wdata;
      end
      if (state == ISSUE) begin
        rdata <= csr_ren ? csr_rdata : '0;
        err <= !legal;
      end
      if (done) ptr <= !id;
    end
  end
  assign p0_req_ready = grant && !win;
  assign p1_req_ready = grant && win;
  assign csr_wen = (state == ISSUE) && legal && we;
  assign csr_ren = (state == ISSUE) && legal && !we;
  assign p0_rsp_valid = (state == RESP) && !id;
  assign p1_rsp_valid = (state == RESP) && id;
  assign p0_rsp_rdata = p0_rsp_valid ? rdata : '0;
  assign p1_rsp_rdata = p1_rsp_valid ? rdata : '0;
  assign p0_rsp_err = p0_rsp_valid && err;
  assign p1_rsp_err = p1_rsp_valid && err;
endmodule
